// File: rtl/dotm_pkg.sv
// Shared types and helpers for the dot-matrix scan driver: phase encoding,
// pin polarity helpers and the row-index decoder.
package dotm_pkg;

   localparam int NUM_ROWS = 8;
   localparam int COL_W    = 8;

   // Default pin polarities; instances may override them.
   localparam bit ROW_ACTIVE_LOW_DEF = 1'b1;
   localparam bit COL_ACTIVE_LOW_DEF = 1'b0;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_e;

   function automatic logic [COL_W-1:0] inactive_lvl(input bit active_low);
      return active_low ? {COL_W{1'b1}} : {COL_W{1'b0}};
   endfunction

   localparam logic [COL_W-1:0] ROW_OFF_DEF = inactive_lvl(ROW_ACTIVE_LOW_DEF);
   localparam logic [COL_W-1:0] COL_OFF_DEF = inactive_lvl(COL_ACTIVE_LOW_DEF);

   function automatic logic [COL_W-1:0] apply_pol(input logic [COL_W-1:0] v,
                                                   input bit active_low);
      return active_low ? ~v : v;
   endfunction

   function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [2:0] idx);
      logic [NUM_ROWS-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/dotm_row_timer.sv
// Row-slot sequencer: tick counter, BLANK/DRIVE phase, row index and the
// frame-start strobe. The tick output exists only when DOTM_PWM_EN is defined.
module dotm_row_timer
   import dotm_pkg::*;
#(
   parameter int ROW_TICKS   = 6250,
   parameter int BLANK_TICKS = 250
) (
   input  logic                          i_Clk,
   input  logic                          i_Rst,
   input  logic                          i_Enable,
   output state_e                        o_State,
`ifdef DOTM_PWM_EN
   output logic [$clog2(ROW_TICKS)-1:0]  o_Tick,
`endif
   output logic [2:0]                    o_Idx,
   output logic                          o_Load,
   output logic                          o_Frame_Start
);

   localparam int TW = $clog2(ROW_TICKS);
   localparam logic [TW-1:0] TICK_LAST  = TW'(ROW_TICKS - 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);

   state_e          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [2:0]      idx_q, idx_d;
   logic            fs_q, fs_d;

   // A frame begins on the first slot of row 0; this also catches the first
   // enabled edge after a disable, since disable parks the sequencer there.
   assign o_Load = i_Enable && (state_q == S_BLANK) && (tick_q == '0) && (idx_q == '0);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      idx_d   = idx_q;
      fs_d    = o_Load;
      if (!i_Enable) begin
         state_d = S_BLANK;
         tick_d  = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            S_BLANK: begin
               tick_d = tick_q + 1'b1;
               if (tick_q == BLANK_LAST) state_d = S_DRIVE;
            end
            S_DRIVE: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  idx_d   = idx_q + 1'b1;
                  state_d = S_BLANK;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q <= S_BLANK;
         tick_q  <= '0;
         idx_q   <= '0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         idx_q   <= idx_d;
         fs_q    <= fs_d;
      end
   end

   assign o_State       = state_q;
   assign o_Idx         = idx_q;
   assign o_Frame_Start = fs_q;
`ifdef DOTM_PWM_EN
   assign o_Tick        = tick_q;
`endif

endmodule

// File: rtl/dotm_scan_driver.sv
// 8x8 dot-matrix scan driver: per-frame map snapshot, registered row/column
// pins with polarity, optional column PWM dimming under DOTM_PWM_EN.
module dotm_scan_driver
   import dotm_pkg::*;
#(
   parameter int ROW_TICKS      = 6250,
   parameter int BLANK_TICKS    = 250,
   parameter bit ROW_ACTIVE_LOW = ROW_ACTIVE_LOW_DEF,
   parameter bit COL_ACTIVE_LOW = COL_ACTIVE_LOW_DEF
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic [63:0] i_Map_Data,
   input  logic        i_Enable,
`ifdef DOTM_PWM_EN
   input  logic [3:0]  i_Duty,
`endif
   output logic [7:0]  o_Row,
   output logic [7:0]  o_Col,
   output logic [2:0]  o_Row_Idx,
   output logic        o_Frame_Start
);

   localparam logic [7:0] ROW_OFF = inactive_lvl(ROW_ACTIVE_LOW);
   localparam logic [7:0] COL_OFF = inactive_lvl(COL_ACTIVE_LOW);

   state_e       state;
   logic [2:0]   idx;
   logic         load;
   logic         col_lit;

   logic [63:0]  shadow_q, shadow_d;
   logic [7:0]   row_q, row_d;
   logic [7:0]   col_q, col_d;
   logic [2:0]   idx_out_q, idx_out_d;

`ifdef DOTM_PWM_EN
   localparam int DRIVE_TICKS = ROW_TICKS - BLANK_TICKS;
   logic [$clog2(ROW_TICKS)-1:0] tick;
   logic [3:0]   duty_q, duty_d;
   logic [31:0]  pwm_pos, pwm_lim;
`endif

   dotm_row_timer #(
      .ROW_TICKS   (ROW_TICKS),
      .BLANK_TICKS (BLANK_TICKS)
   ) u_timer (
      .i_Clk         (i_Clk),
      .i_Rst         (i_Rst),
      .i_Enable      (i_Enable),
      .o_State       (state),
`ifdef DOTM_PWM_EN
      .o_Tick        (tick),
`endif
      .o_Idx         (idx),
      .o_Load        (load),
      .o_Frame_Start (o_Frame_Start)
   );

`ifdef DOTM_PWM_EN
   // Only meaningful in DRIVE, where tick >= BLANK_TICKS.
   always_comb begin
      pwm_pos = (32'(tick) - 32'(BLANK_TICKS)) << 4;
      pwm_lim = (32'(duty_q) + 32'd1) * 32'(DRIVE_TICKS);
      col_lit = pwm_pos < pwm_lim;
      duty_d  = load ? i_Duty : duty_q;
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) duty_q <= 4'hF;
      else        duty_q <= duty_d;
   end
`else
   assign col_lit = 1'b1;
`endif

   // Pins follow the sequencer one cycle late; the row index is delayed the
   // same way so it only ever changes during a blank cycle.
   always_comb begin
      shadow_d  = load ? i_Map_Data : shadow_q;
      row_d     = ROW_OFF;
      col_d     = COL_OFF;
      idx_out_d = '0;
      if (i_Enable) begin
         idx_out_d = idx;
         if (state == S_DRIVE) begin
            row_d = apply_pol(row_onehot(idx), ROW_ACTIVE_LOW);
            col_d = col_lit ? apply_pol(shadow_q[{idx, 3'b000} +: 8], COL_ACTIVE_LOW)
                            : COL_OFF;
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         shadow_q  <= '0;
         row_q     <= ROW_OFF;
         col_q     <= COL_OFF;
         idx_out_q <= '0;
      end else begin
         shadow_q  <= shadow_d;
         row_q     <= row_d;
         col_q     <= col_d;
         idx_out_q <= idx_out_d;
      end
   end

   assign o_Row     = row_q;
   assign o_Col     = col_q;
   assign o_Row_Idx = idx_out_q;

endmodule

// File: tb/tb_dotm_scan_driver.sv
// Bench for dotm_scan_driver: frame-position model checked every cycle plus
// hand-computed pin values at key points; PWM part active under DOTM_PWM_EN.
module tb_dotm_scan_driver;

   localparam int RA = 8;
   localparam int BA = 2;
   localparam int RW = 34;
   localparam int BW = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        en    = 1'b1;
   logic [63:0] map   = 64'h0102040810204080;
   logic [3:0]  duty  = 4'd15;

   logic [7:0]  row_a, col_a, row_p, col_p;
   logic [2:0]  idx_a, idx_p;
   logic        fs_a, fs_p;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: cycles since the last load from idle, snapshots per frame length
   int          k      = 0;
   bit          idle   = 1'b1;
   logic [63:0] snap_a = '0;
   int          duty_a = 15;

   always #5 clk = ~clk;

   dotm_scan_driver #(.ROW_TICKS(RA), .BLANK_TICKS(BA),
                      .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b0)) dut (
      .i_Clk(clk), .i_Rst(rst_n), .i_Map_Data(map), .i_Enable(en),
`ifdef DOTM_PWM_EN
      .i_Duty(duty),
`endif
      .o_Row(row_a), .o_Col(col_a), .o_Row_Idx(idx_a), .o_Frame_Start(fs_a));

   dotm_scan_driver #(.ROW_TICKS(RA), .BLANK_TICKS(BA),
                      .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b1)) dut_p (
      .i_Clk(clk), .i_Rst(rst_n), .i_Map_Data(map), .i_Enable(en),
`ifdef DOTM_PWM_EN
      .i_Duty(duty),
`endif
      .o_Row(row_p), .o_Col(col_p), .o_Row_Idx(idx_p), .o_Frame_Start(fs_p));

`ifdef DOTM_PWM_EN
   logic [7:0]  row_w, col_w;
   logic [2:0]  idx_w;
   logic        fs_w;
   logic [63:0] snap_w = '0;
   int          duty_w = 15;

   dotm_scan_driver #(.ROW_TICKS(RW), .BLANK_TICKS(BW),
                      .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b0)) dut_w (
      .i_Clk(clk), .i_Rst(rst_n), .i_Map_Data(map), .i_Enable(en),
      .i_Duty(duty),
      .o_Row(row_w), .o_Col(col_w), .o_Row_Idx(idx_w), .o_Frame_Start(fs_w));
`endif

   // Pin values at frame position kk: slot s, row s/R, tick s%R, lit when
   // past the blank gap and inside the duty window.
   function automatic void exp_out(input int kk, input bit idl, input int R, input int B,
                                   input logic [63:0] snap, input int dt,
                                   input bit ral, input bit cal,
                                   output logic [7:0] er, output logic [7:0] ec,
                                   output logic [2:0] ei, output logic ef);
      int s, r, t;
      logic [7:0] rv, cv;
      s  = kk % (8 * R);
      r  = s / R;
      t  = s % R;
      rv = 8'h00;
      cv = 8'h00;
      ei = 3'd0;
      ef = 1'b0;
      if (!idl) begin
         ei = 3'(r);
         ef = (s == 0);
         if (t >= B) begin
            rv = 8'h01 << r;
            if ((t - B) * 16 < (dt + 1) * (R - B)) cv = snap[8*r +: 8];
         end
      end
      er = ral ? ~rv : rv;
      ec = cal ? ~cv : cv;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle = 1'b1;
      end else if (!en) begin
         idle = 1'b1;
      end else if (idle) begin
         idle   = 1'b0;
         k      = 0;
         snap_a = map;
         duty_a = int'(duty);
`ifdef DOTM_PWM_EN
         snap_w = map;
         duty_w = int'(duty);
`endif
      end else begin
         k++;
         if (k % (8 * RA) == 0) begin
            snap_a = map;
            duty_a = int'(duty);
         end
`ifdef DOTM_PWM_EN
         if (k % (8 * RW) == 0) begin
            snap_w = map;
            duty_w = int'(duty);
         end
`endif
      end
   end

   always @(negedge clk) begin
      logic [7:0] er, ec;
      logic [2:0] ei;
      logic       ef;
      exp_out(k, idle, RA, BA, snap_a, duty_a, 1'b1, 1'b0, er, ec, ei, ef);
      chk("a_row", 64'(row_a), 64'(er));
      chk("a_col", 64'(col_a), 64'(ec));
      chk("a_idx", 64'(idx_a), 64'(ei));
      chk("a_fs",  64'(fs_a),  64'(ef));
      exp_out(k, idle, RA, BA, snap_a, duty_a, 1'b0, 1'b1, er, ec, ei, ef);
      chk("p_row", 64'(row_p), 64'(er));
      chk("p_col", 64'(col_p), 64'(ec));
      chk("p_idx", 64'(idx_p), 64'(ei));
      chk("p_fs",  64'(fs_p),  64'(ef));
`ifdef DOTM_PWM_EN
      exp_out(k, idle, RW, BW, snap_w, duty_w, 1'b1, 1'b0, er, ec, ei, ef);
      chk("w_row", 64'(row_w), 64'(er));
      chk("w_col", 64'(col_w), 64'(ec));
      chk("w_idx", 64'(idx_w), 64'(ei));
      chk("w_fs",  64'(fs_w),  64'(ef));
`endif
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge with reset asserted; leaves the frame at slot 10.
   task automatic reset_seq();
      #2 rst_n = 1'b1;
      step(1);
      chk("rs_fs1",  64'(fs_a), 64'h1);
      chk("rs_row1", 64'(row_a), 64'hFF);
      step(1);
      chk("rs_fs2",  64'(fs_a), 64'h0);
      chk("rs_row2", 64'(row_a), 64'hFF);
      step(1);
      chk("rs_row3", 64'(row_a), 64'hFE);
      chk("rs_col3", 64'(col_a), 64'h80);
      step(5);
      chk("rs_row8", 64'(row_a), 64'hFE);
      step(1);
      chk("rs_row9", 64'(row_a), 64'hFF);
      chk("rs_idx9", 64'(idx_a), 64'h1);
      step(2);
      chk("rs_row11", 64'(row_a), 64'hFD);
      chk("rs_col11", 64'(col_a), 64'h40);
   endtask

`ifdef DOTM_PWM_EN
   task automatic wait_fs_w();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (fs_w) begin
            ok = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL w_fs_wait: got no frame start, expected one within 600 cycles");
      end
   endtask

   task automatic count_lit(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         if (col_w != 8'h00) cnt++;
      end
   endtask
`endif

   initial begin
      step(3);
      chk("rst_row", 64'(row_a), 64'hFF);
      chk("rst_col", 64'(col_a), 64'h00);
      chk("rst_idx", 64'(idx_a), 64'h0);
      chk("rst_fs",  64'(fs_a),  64'h0);
      reset_seq();

      // tear-free snapshot: map changes during row 3
      step(16);
      chk("tf_col_r3_old", 64'(col_a), 64'h10);
      #2 map = '1;
      step(8);
      chk("tf_col_r4_old", 64'(col_a), 64'h08);
      step(30);
      chk("tf_fs_64", 64'(fs_a), 64'h1);
      step(26);
      chk("tf_row_r3_new", 64'(row_a), 64'hF7);
      chk("tf_col_r3_new", 64'(col_a), 64'hFF);
      step(38);
      chk("tf_fs_128", 64'(fs_a), 64'h1);

      // disable during row 5 DRIVE, then re-enable
      step(44);
      chk("en_row5", 64'(row_a), 64'hDF);
      #2 en = 1'b0;
      step(1);
      chk("dis_row", 64'(row_a), 64'hFF);
      chk("dis_col", 64'(col_a), 64'h00);
      chk("dis_idx", 64'(idx_a), 64'h0);
      step(3);
      #2 en = 1'b1;
      step(1);
      chk("ren_fs",   64'(fs_a), 64'h1);
      chk("ren_row1", 64'(row_a), 64'hFF);
      step(1);
      chk("ren_row2", 64'(row_a), 64'hFF);
      step(1);
      chk("ren_row3", 64'(row_a), 64'hFE);
      chk("ren_col3", 64'(col_a), 64'hFF);

      // asynchronous reset in the middle of DRIVE
      step(10);
      chk("ar_pre_row", 64'(row_a), 64'hFD);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_row", 64'(row_a), 64'hFF);
      chk("ar_col", 64'(col_a), 64'h00);
      chk("ar_idx", 64'(idx_a), 64'h0);
      map = 64'h0102040810204080;
      step(1);
      reset_seq();

      // polarity instance with row 0 = 8'h03
      #2 map = 64'hFFFF_FFFF_FFFF_FF03;
      step(54);
      chk("pol_blank_row", 64'(row_p), 64'h00);
      chk("pol_blank_col", 64'(col_p), 64'hFF);
      step(2);
      chk("pol_drive_row", 64'(row_p), 64'h01);
      chk("pol_drive_col", 64'(col_p), 64'hFC);
      chk("pol_a_col",     64'(col_a), 64'h03);

`ifdef DOTM_PWM_EN
      begin
         int cnt;
         #2 duty = 4'd7;
         wait_fs_w();
         count_lit(RW, cnt);
         chk("pwm_d7_row0", 64'(cnt), 64'd16);
         #2 duty = 4'd3;
         step(1);
         count_lit(RW, cnt);
         chk("pwm_d7_row1_hold", 64'(cnt), 64'd16);
         wait_fs_w();
         count_lit(RW, cnt);
         chk("pwm_d3_row0", 64'(cnt), 64'd8);
      end
`endif

      step(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
